// File: rtl/cpu_regfile_async_nrmw_if.sv
// Register-file access bundle: read/write address and data buses plus
// the busy and out-of-bounds status lines.
interface cpu_regfile_async_nrmw_if #(
    parameter int p_data_width  = 32,
    parameter int p_nb_rd_ports = 2,
    parameter int p_nb_wr_ports = 1
);
    logic                                   o_busy;
    logic                                   o_addr_oob;
    logic [5*p_nb_rd_ports-1:0]             i_rd_addr;
    logic [p_data_width*p_nb_rd_ports-1:0]  o_rd_data;
    logic [p_nb_wr_ports-1:0]               i_wr_en;
    logic [5*p_nb_wr_ports-1:0]             i_wr_addr;
    logic [p_data_width*p_nb_wr_ports-1:0]  i_wr_data;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  o_rd_data, o_busy, o_addr_oob
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        output o_rd_data, o_busy, o_addr_oob
    );
endinterface

// File: rtl/cpu_regfile_async_nrmw.sv
// Multi-port register file: N combinational read ports, M clocked write ports,
// x0 hardwired to zero, optional write-to-read bypass and post-reset clear.
module cpu_regfile_async_nrmw_rd_port #(
    parameter int p_data_width  = 32,
    parameter int p_addr_w      = 5,
    parameter int p_depth       = 32,
    parameter int p_nb_wr_ports = 1,
    parameter int p_bypass      = 1
) (
    input  logic                                        i_clearing,
    input  logic [p_addr_w-1:0]                         i_addr,
    input  logic [p_depth-1:0][p_data_width-1:0]        i_regs,
    input  logic [p_nb_wr_ports-1:0]                    i_wr_eff,
    input  logic [p_nb_wr_ports-1:0][p_addr_w-1:0]      i_wr_addr,
    input  logic [p_nb_wr_ports-1:0][p_data_width-1:0]  i_wr_data,
    output logic [p_data_width-1:0]                     o_data
);
    always_comb begin
        o_data = i_regs[i_addr];
        // ascending scan so the highest-index matching write port wins
        for (int j = 0; j < p_nb_wr_ports; j++) begin
            if ((p_bypass != 0) && i_wr_eff[j] && (i_wr_addr[j] == i_addr)) begin
                o_data = i_wr_data[j];
            end
        end
        if (i_clearing || (i_addr == '0)) begin
            o_data = '0;
        end
    end
endmodule

module cpu_regfile_async_nrmw #(
    parameter int p_data_width     = 32,
    parameter int p_half_regfile   = 0,
    parameter int p_nb_rd_ports    = 2,
    parameter int p_nb_wr_ports    = 1,
    parameter int p_bypass         = 1,
    parameter int p_clear_on_reset = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    cpu_regfile_async_nrmw_if.slave      bus
);
    localparam int D  = (p_half_regfile != 0) ? 16 : 32;
    localparam int AW = (p_half_regfile != 0) ? 4 : 5;
    localparam int NR = p_nb_rd_ports;
    localparam int NW = p_nb_wr_ports;
    localparam int DW = p_data_width;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                       state_q, state_d;
    logic [AW-1:0]                clear_idx_q, clear_idx_d;
    // x0 has no storage; the read view splices in a constant zero word
    logic [D-1:1][DW-1:0]         regs_q, regs_d;
    logic [D-1:0][DW-1:0]         rd_view;

    logic [NR-1:0][4:0]           rd_addr_raw;
    logic [NW-1:0][4:0]           wr_addr_raw;
    logic [NR-1:0][AW-1:0]        rd_addr;
    logic [NW-1:0][AW-1:0]        wr_addr;
    logic [NW-1:0][DW-1:0]        wr_data;
    logic [NW-1:0]                wr_eff;
    logic [NR-1:0][DW-1:0]        rd_data;
    logic                         clearing;
    logic                         addr_oob;

    assign rd_addr_raw = bus.i_rd_addr;
    assign wr_addr_raw = bus.i_wr_addr;
    assign wr_data     = bus.i_wr_data;
    assign clearing    = (state_q == ST_CLEAR);
    assign rd_view     = {regs_q, {DW{1'b0}}};

    always_comb begin
        for (int k = 0; k < NR; k++) rd_addr[k] = rd_addr_raw[k][AW-1:0];
        for (int j = 0; j < NW; j++) begin
            wr_addr[j] = wr_addr_raw[j][AW-1:0];
            wr_eff[j]  = bus.i_wr_en[j] && (wr_addr[j] != '0) && (state_q == ST_READY);
        end
    end

    // bit 4 is meaningless in the 16-entry file, so flag any use of it
    always_comb begin
        addr_oob = 1'b0;
        if (p_half_regfile != 0) begin
            for (int k = 0; k < NR; k++) addr_oob = addr_oob | rd_addr_raw[k][4];
            for (int j = 0; j < NW; j++) addr_oob = addr_oob | (bus.i_wr_en[j] & wr_addr_raw[j][4]);
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        regs_d      = regs_q;
        case (state_q)
            ST_CLEAR: begin
                clear_idx_d = clear_idx_q + AW'(1);
                if (clear_idx_q == AW'(D-1)) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
        for (int i = 1; i < D; i++) begin
            if (state_q == ST_CLEAR) begin
                if (clear_idx_q == AW'(i)) regs_d[i] = '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_eff[j] && (wr_addr[j] == AW'(i))) regs_d[i] = wr_data[j];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= (p_clear_on_reset != 0) ? ST_CLEAR : ST_READY;
            clear_idx_q <= AW'(1);
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // storage itself carries no reset; the clear sequencer provides it
    always_ff @(posedge i_clk) begin
        if (!i_rst) regs_q <= regs_d;
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        cpu_regfile_async_nrmw_rd_port #(
            .p_data_width  (DW),
            .p_addr_w      (AW),
            .p_depth       (D),
            .p_nb_wr_ports (NW),
            .p_bypass      (p_bypass)
        ) u_rd (
            .i_clearing (clearing),
            .i_addr     (rd_addr[k]),
            .i_regs     (rd_view),
            .i_wr_eff   (wr_eff),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .o_data     (rd_data[k])
        );
    end

    assign bus.o_rd_data  = rd_data;
    assign bus.o_busy     = clearing;
    assign bus.o_addr_oob = addr_oob;
endmodule

// File: tb/tb_cpu_regfile_async_nrmw.sv
// Bench for cpu_regfile_async_nrmw: four configurations sharing one clock and
// reset, vector table plus scoreboard-checked sequences and a random soak.
module tb_cpu_regfile_async_nrmw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    // a: full, 2R2W bypass; h: half 2R1W; n: full no bypass; w: 64-bit 4R2W
    cpu_regfile_async_nrmw_if #(.p_data_width(32), .p_nb_rd_ports(2), .p_nb_wr_ports(2)) a_if();
    cpu_regfile_async_nrmw_if #(.p_data_width(32), .p_nb_rd_ports(2), .p_nb_wr_ports(1)) h_if();
    cpu_regfile_async_nrmw_if #(.p_data_width(32), .p_nb_rd_ports(2), .p_nb_wr_ports(1)) n_if();
    cpu_regfile_async_nrmw_if #(.p_data_width(64), .p_nb_rd_ports(4), .p_nb_wr_ports(2)) w_if();

    cpu_regfile_async_nrmw #(.p_data_width(32), .p_half_regfile(0), .p_nb_rd_ports(2),
        .p_nb_wr_ports(2), .p_bypass(1), .p_clear_on_reset(1))
        u_a (.i_clk(clk), .i_rst(rst), .bus(a_if.slave));
    cpu_regfile_async_nrmw #(.p_data_width(32), .p_half_regfile(1), .p_nb_rd_ports(2),
        .p_nb_wr_ports(1), .p_bypass(1), .p_clear_on_reset(1))
        u_h (.i_clk(clk), .i_rst(rst), .bus(h_if.slave));
    cpu_regfile_async_nrmw #(.p_data_width(32), .p_half_regfile(0), .p_nb_rd_ports(2),
        .p_nb_wr_ports(1), .p_bypass(0), .p_clear_on_reset(1))
        u_n (.i_clk(clk), .i_rst(rst), .bus(n_if.slave));
    cpu_regfile_async_nrmw #(.p_data_width(64), .p_half_regfile(0), .p_nb_rd_ports(4),
        .p_nb_wr_ports(2), .p_bypass(1), .p_clear_on_reset(1))
        u_w (.i_clk(clk), .i_rst(rst), .bus(w_if.slave));

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
    } vec_t;
    localparam int NV = 10;
    vec_t vt[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [63:0] act);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            check(name, act, sb_q.pop_front());
        end
    endtask

    task automatic idle();
        a_if.i_wr_en = '0; a_if.i_wr_addr = '0; a_if.i_wr_data = '0; a_if.i_rd_addr = '0;
        h_if.i_wr_en = '0; h_if.i_wr_addr = '0; h_if.i_wr_data = '0; h_if.i_rd_addr = '0;
        n_if.i_wr_en = '0; n_if.i_wr_addr = '0; n_if.i_wr_data = '0; n_if.i_rd_addr = '0;
        w_if.i_wr_en = '0; w_if.i_wr_addr = '0; w_if.i_wr_data = '0; w_if.i_rd_addr = '0;
    endtask

    // Called right after reset is released on a falling edge; counts cycles with busy high.
    task automatic count_busy(output int ca, output int ch, output int cn, output int cw,
                              input bit drop_wr);
        ca = 0; ch = 0; cn = 0; cw = 0;
        for (int i = 0; i < 60; i++) begin
            if (a_if.o_busy) ca++;
            if (h_if.o_busy) ch++;
            if (n_if.o_busy) cn++;
            if (w_if.o_busy) cw++;
            if (drop_wr && i == 5) begin
                a_if.i_wr_en = 2'b01; a_if.i_wr_addr = {5'd0, 5'd3};
                a_if.i_wr_data = {32'h0, 32'h0000_1234};
            end else if (drop_wr && i == 6) begin
                a_if.i_wr_en = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic a_read(input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        a_if.i_wr_en = '0; a_if.i_rd_addr = {r1, r0};
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, ch, cn, cw;
        logic [63:0] m[32];
        logic [1:0]  wen;
        logic [4:0]  wa[2];
        logic [63:0] wd[2];
        logic [4:0]  ra[4];
        logic [63:0] e;

        vt[0] = '{2'b01, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        vt[1] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        vt[2] = '{2'b01, 5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0,         5'd1,  5'd7,  32'h0,         32'hA5A5_A5A5};
        vt[3] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vt[4] = '{2'b11, 5'd9,  5'd9,  32'h1111_1111, 32'h2222_2222, 5'd9,  5'd9,  32'h2222_2222, 32'h2222_2222};
        vt[5] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd9,  5'd0,  32'h2222_2222, 32'h0};
        vt[6] = '{2'b11, 5'd9,  5'd10, 32'h0000_0009, 32'h0000_0010, 5'd9,  5'd10, 32'h0000_0009, 32'h0000_0010};
        vt[7] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd9,  5'd10, 32'h0000_0009, 32'h0000_0010};
        vt[8] = '{2'b10, 5'd31, 5'd31, 32'h0000_0BAD, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0};
        vt[9] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd31, 5'd0,  32'hCAFE_F00D, 32'h0};

        idle();
        a_if.i_rd_addr = {5'd5, 5'd7};
        repeat (2) @(negedge clk);
        check("rst_busy_a", {63'd0, a_if.o_busy}, 64'd1);
        check("rst_busy_h", {63'd0, h_if.o_busy}, 64'd1);
        check("rst_rd_a", {32'd0, a_if.o_rd_data}, 64'd0);
        check("rst_oob_a", {63'd0, a_if.o_addr_oob}, 64'd0);

        rst = 1'b0;
        count_busy(ca, ch, cn, cw, 1'b0);
        check("clr_len_full", 64'(ca), 64'd31);
        check("clr_len_half", 64'(ch), 64'd15);
        check("clr_len_nobyp", 64'(cn), 64'd31);
        check("clr_len_wide", 64'(cw), 64'd31);

        // vector table on the full bypass config
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_if.i_wr_en   = vt[i].wen;
            a_if.i_wr_addr = {vt[i].wa1, vt[i].wa0};
            a_if.i_wr_data = {vt[i].wd1, vt[i].wd0};
            a_if.i_rd_addr = {vt[i].ra1, vt[i].ra0};
            sb_q.push_back({32'd0, vt[i].e0});
            sb_q.push_back({32'd0, vt[i].e1});
            #1;
            sb_check($sformatf("tbl%0d_p0", i), {32'd0, a_if.o_rd_data[31:0]});
            sb_check($sformatf("tbl%0d_p1", i), {32'd0, a_if.o_rd_data[63:32]});
        end

        // full mode never flags out-of-bounds
        a_read(5'd17, 5'd0);
        check("full_oob", {63'd0, a_if.o_addr_oob}, 64'd0);
        check("full_rd_x17", {32'd0, a_if.o_rd_data[31:0]}, 64'd0);

        // clear wipes earlier contents
        @(negedge clk);
        a_if.i_wr_en = 2'b01; a_if.i_wr_addr = {5'd0, 5'd5}; a_if.i_wr_data = {32'h0, 32'hDEAD_BEEF};
        a_read(5'd5, 5'd0);
        check("x5_written", {32'd0, a_if.o_rd_data[31:0]}, 64'hDEAD_BEEF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(ca, ch, cn, cw, 1'b0);
        check("reclr_len_full", 64'(ca), 64'd31);
        check("reclr_len_half", 64'(ch), 64'd15);
        a_read(5'd5, 5'd7);
        check("x5_cleared", {32'd0, a_if.o_rd_data[31:0]}, 64'd0);
        check("x7_cleared", {32'd0, a_if.o_rd_data[63:32]}, 64'd0);

        // reset mid-clear restarts the full count; writes while busy are dropped
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midclr_busy", {63'd0, a_if.o_busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(ca, ch, cn, cw, 1'b1);
        check("midclr_len_full", 64'(ca), 64'd31);
        check("midclr_len_half", 64'(ch), 64'd15);
        a_read(5'd3, 5'd0);
        check("busy_wr_dropped", {32'd0, a_if.o_rd_data[31:0]}, 64'd0);

        // no-bypass config: old data same cycle, new data next cycle
        @(negedge clk);
        n_if.i_wr_en = 1'b1; n_if.i_wr_addr = 5'd7; n_if.i_wr_data = 32'h0000_0011;
        @(negedge clk);
        n_if.i_wr_data = 32'hA5A5_A5A5; n_if.i_rd_addr = {5'd7, 5'd0};
        #1;
        check("nobyp_old", {32'd0, n_if.o_rd_data[63:32]}, 64'h11);
        @(negedge clk);
        n_if.i_wr_en = 1'b0;
        #1;
        check("nobyp_new", {32'd0, n_if.o_rd_data[63:32]}, 64'hA5A5_A5A5);
        @(negedge clk);
        n_if.i_wr_en = 1'b1; n_if.i_wr_addr = 5'd0; n_if.i_wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_if.i_wr_en = 1'b0; n_if.i_rd_addr = {5'd0, 5'd0};
        #1;
        check("nobyp_x0", {32'd0, n_if.o_rd_data[31:0]}, 64'd0);

        // half mode: bit 4 ignored for addressing but raises oob
        @(negedge clk);
        h_if.i_wr_en = 1'b1; h_if.i_wr_addr = 5'd1; h_if.i_wr_data = 32'h0000_1111;
        #1;
        check("half_oob_clean", {63'd0, h_if.o_addr_oob}, 64'd0);
        @(negedge clk);
        h_if.i_wr_en = 1'b0; h_if.i_rd_addr = {5'd0, 5'd17};
        #1;
        check("half_oob_rd", {63'd0, h_if.o_addr_oob}, 64'd1);
        check("half_rd_alias", {32'd0, h_if.o_rd_data[31:0]}, 64'h1111);
        @(negedge clk);
        h_if.i_rd_addr = '0; h_if.i_wr_addr = 5'd20; h_if.i_wr_data = 32'h0000_4444;
        #1;
        check("half_oob_wr_off", {63'd0, h_if.o_addr_oob}, 64'd0);
        @(negedge clk);
        h_if.i_wr_en = 1'b1;
        #1;
        check("half_oob_wr_on", {63'd0, h_if.o_addr_oob}, 64'd1);
        @(negedge clk);
        h_if.i_wr_en = 1'b0; h_if.i_rd_addr = {5'd4, 5'd4};
        #1;
        check("half_wr_alias", {32'd0, h_if.o_rd_data[31:0]}, 64'h4444);
        check("half_oob_after", {63'd0, h_if.o_addr_oob}, 64'd0);

        // wide config random soak against a reference array
        for (int i = 0; i < 32; i++) m[i] = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            wen = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                wa[j] = ($urandom_range(0, 3) == 0) ? 5'd9 : 5'($urandom_range(0, 31));
                wd[j] = {$urandom, $urandom};
            end
            for (int k = 0; k < 4; k++)
                ra[k] = ($urandom_range(0, 2) == 0) ? wa[k % 2] : 5'($urandom_range(0, 31));
            w_if.i_wr_en   = wen;
            w_if.i_wr_addr = {wa[1], wa[0]};
            w_if.i_wr_data = {wd[1], wd[0]};
            w_if.i_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
            for (int k = 0; k < 4; k++) begin
                e = m[ra[k]];
                for (int j = 0; j < 2; j++)
                    if (wen[j] && wa[j] == ra[k]) e = wd[j];
                if (ra[k] == 5'd0) e = '0;
                sb_q.push_back(e);
            end
            #1;
            for (int k = 0; k < 4; k++)
                sb_check($sformatf("wide_c%0d_p%0d", c, k), w_if.o_rd_data[64*k +: 64]);
            for (int j = 0; j < 2; j++)
                if (wen[j] && wa[j] != 5'd0) m[wa[j]] = wd[j];
        end

        @(negedge clk);
        idle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_async_nrmw.md
# cpu_regfile_async_nrmw

Parametrised multi-port register file for the AsteRISC core: N asynchronous read ports, M synchronous write ports, configurable data width and 16/32-entry depth. x0 is hardwired to zero, and an optional same-cycle write-to-read bypass is provided. An optional post-reset clear sequencer zeroes the array and holds `o_busy` high until every register has been cleared. It replaces the fixed 2R1W register file wherever the pipeline needs more ports, bypassing or deterministic register contents after reset.

## Interface
- p_data_width, 32, register width in bits
- p_half_regfile, 0, 1 gives 16 registers (x0..x15), 0 gives 32
- p_nb_rd_ports, 2, number of read ports (>=1)
- p_nb_wr_ports, 1, number of write ports (>=1)
- p_bypass, 1, 1 makes a read of an address being written this cycle return the incoming write data
- p_clear_on_reset, 1, 1 enables the post-reset clear sequencer
- i_clk  in  1  global clock
- i_rst  in  1  global reset; synchronous, active-high
- o_busy  out  1  high while the clear sequencer runs
- o_addr_oob  out  1  address out of bounds (half mode only)
- i_rd_addr  in  5*p_nb_rd_ports  read addresses; port k uses bits [5k+:5]
- o_rd_data  out  p_data_width*p_nb_rd_ports  read data; port k uses bits [p_data_width*k+:p_data_width]
- i_wr_en  in  p_nb_wr_ports  write enables; bit j belongs to write port j
- i_wr_addr  in  5*p_nb_wr_ports  write addresses; port j uses bits [5j+:5]
- i_wr_data  in  p_data_width*p_nb_wr_ports  write data; port j uses bits [p_data_width*j+:p_data_width]

## Operation
- Depth D is 16 when p_half_regfile=1, else 32. All addresses are truncated to 4 bits in half mode.
- o_addr_oob (combinational, half mode only) is high when any read address has bit 4 set, or any enabled write port's address has bit 4 set. It is always 0 in full mode.
- Write port j is effective when i_wr_en[j]=1, its truncated address is non-zero and the state is READY.
- Write collision: if several effective ports target the same address, the highest-index port wins.
- Read port k:
  - returns 0 when its truncated address is 0, or when the state is CLEAR;
  - otherwise, when p_bypass=1 and an effective write targets the same address this cycle, returns that port's i_wr_data (highest index wins);
  - otherwise returns the array contents.
- Clear sequencer FSM, state and counter clear_idx (width log2(D)):
  - CLEAR: writes 0 to regs[clear_idx], then increments clear_idx. When clear_idx = D-1, the next state is READY. All user writes are ignored.
  - READY: normal operation; stays in READY until reset.
  - i_rst=1 loads state=CLEAR and clear_idx=1 (or state=READY when p_clear_on_reset=0). No array entry is written while i_rst=1.
- o_busy = (state == CLEAR).
- With p_clear_on_reset=0 the array has no reset: contents are undefined until written, and o_busy is 0 from reset onward.
- x0 storage is never written. It is always read as 0.

## Timing
- Reads are fully combinational from i_rd_addr, the array and (with bypass) i_wr_*.
- Writes take effect at the rising edge. Without bypass, a read in the next cycle returns the new value.
- Reset values: state=CLEAR, o_busy=1 and o_rd_data all 0 (when p_clear_on_reset=1). o_addr_oob depends only on its inputs.
- Clear length: o_busy stays high for exactly D-1 rising edges with i_rst=0 (31 full, 15 half), and falls after the edge that clears regs[D-1]. The first user write is accepted on the following edge.
- Reset mid-clear: the sequencer restarts at clear_idx=1 and the full D-1 cycle count applies again.
- Holding reset asserted keeps o_busy=1 and clear_idx=1 indefinitely.
- Simultaneous read and write to the same address: p_bypass=1 returns the new data in the same cycle; p_bypass=0 returns the old data.

## Test plan
- Clear sequence: full mode, defaults. Write 0xDEADBEEF to x5, pulse i_rst for 1 cycle, then count cycles -> o_busy high for exactly 31 cycles, and reading x5 afterwards returns 0x00000000. Repeat in half mode -> 15 cycles.
- Reset mid-clear: assert i_rst again 10 cycles into a clear -> o_busy stays high for 31 further cycles after release. A write of 0x1234 to x3 during busy is dropped, and reading x3 returns 0.
- x0 and bypass: write 0xFFFFFFFF to x0 -> every read port returns 0. With p_bypass=1, write 0xA5A5A5A5 to x7 while read port 1 reads x7 -> 0xA5A5A5A5 in the same cycle. With p_bypass=0 -> the old value in the same cycle and 0xA5A5A5A5 in the next cycle.
- Multi-write collision: p_nb_wr_ports=2, both ports write x9 (port0 0x11111111, port1 0x22222222) -> x9 reads 0x22222222. Different addresses (x9, x10) -> both are stored.
- Half-mode OOB: read address 5'd17 -> o_addr_oob=1 and the port reads x1. Write address 5'd20 with i_wr_en=0 -> o_addr_oob=0. With i_wr_en=1 -> o_addr_oob=1 and x4 is written.
- Wide config: p_data_width=64, 4 read ports, 2 write ports -> after clear, random writes and reads across all ports match a reference model over 1000 cycles.
